// File: rtl/ft_rca_pkg.sv
// Shared types and helpers for the chunked TMR ripple-carry adder.
// Combinational only; no state, no flow control.
package ft_rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        VOTE_ALL  = 2'd0,
        VOTE_TWO  = 2'd1,
        VOTE_NONE = 2'd2
    } vote_t;

    // Width of one replica result: CHUNK sum bits plus the chunk carry.
    function automatic int vec_w(input int chunk);
        return chunk + 1;
    endfunction

    function automatic logic maj_bit(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // e01 && e02 implies e12, so full agreement only needs two compares.
    function automatic vote_t classify(input logic e01, input logic e02, input logic e12);
        if (e01 && e02)
            return VOTE_ALL;
        else if (e01 || e02 || e12)
            return VOTE_TWO;
        else
            return VOTE_NONE;
    endfunction

endpackage

// File: rtl/tmr_chunk_add.sv
// Three replica CHUNK-bit adders with per-replica fault injection and a 2-of-3 voter.
// Purely combinational (0 cycles); no backpressure.
// Vote output is always the bitwise majority, which equals the agreeing pair whenever two match.
module tmr_chunk_add
    import ft_rca_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]        a_chk,
    input  logic [CHUNK-1:0]        b_chk,
    input  logic                    cin,
    input  logic [2:0]              fi_en,
    input  logic [CHUNK-1:0]        fi_mask,
    output logic [vec_w(CHUNK)-1:0] vote,
    output vote_t                   cls
);

    localparam int VW = vec_w(CHUNK);

    logic [2:0][CHUNK-1:0] rot;
    logic [2:0][VW-1:0]    rep;
    logic                  e01;
    logic                  e02;
    logic                  e12;

    for (genvar r = 0; r < 3; r++) begin : g_rep
        // Replica r sees the injection mask rotated left by r bits.
        for (genvar i = 0; i < CHUNK; i++) begin : g_rot
            assign rot[r][i] = fi_mask[(i + CHUNK - (r % CHUNK)) % CHUNK];
        end
        assign rep[r] = (VW'(a_chk) + VW'(b_chk) + VW'(cin))
                      ^ {1'b0, (fi_en[r] ? rot[r] : {CHUNK{1'b0}})};
    end

    for (genvar i = 0; i < VW; i++) begin : g_vote
        assign vote[i] = maj_bit(rep[0][i], rep[1][i], rep[2][i]);
    end

    assign e01 = (rep[0] == rep[1]);
    assign e02 = (rep[0] == rep[2]);
    assign e12 = (rep[1] == rep[2]);
    assign cls = classify(e01, e02, e12);

endmodule

// File: rtl/ft_rca_seq.sv
// Sequential fault-tolerant adder: one TMR-voted CHUNK slice per cycle.
// Latency WIDTH/CHUNK CALC cycles plus one per retry; result in the following cycle.
// Single operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module ft_rca_seq
    import ft_rca_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CHUNK     = 4,
    parameter int RETRY_MAX = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       fi_en,
    input  logic [CHUNK-1:0] fi_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err_corr,
    output logic             err_uncorr
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int RW     = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int VW     = vec_w(CHUNK);

    localparam logic [KW-1:0] LAST_K    = KW'(NCHUNK - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

    if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_width
        $error("ft_rca_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state_q, state_n;
    logic [KW-1:0]    k_q, k_n;
    logic [RW-1:0]    retry_q, retry_n;
    logic             carry_q, carry_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] sum_q, sum_n;
    logic             cout_q, cout_n;
    logic             corr_q, corr_n;
    logic             uncorr_q, uncorr_n;

    logic [VW-1:0]    vote;
    vote_t            cls;

    tmr_chunk_add #(
        .CHUNK (CHUNK)
    ) u_tmr (
        .a_chk   (a_q[k_q*CHUNK +: CHUNK]),
        .b_chk   (b_q[k_q*CHUNK +: CHUNK]),
        .cin     (carry_q),
        .fi_en   (fi_en),
        .fi_mask (fi_mask),
        .vote    (vote),
        .cls     (cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            retry_q  <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            corr_q   <= 1'b0;
            uncorr_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            k_q      <= k_n;
            retry_q  <= retry_n;
            carry_q  <= carry_n;
            a_q      <= a_n;
            b_q      <= b_n;
            sum_q    <= sum_n;
            cout_q   <= cout_n;
            corr_q   <= corr_n;
            uncorr_q <= uncorr_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        k_n      = k_q;
        retry_n  = retry_q;
        carry_n  = carry_q;
        a_n      = a_q;
        b_n      = b_q;
        sum_n    = sum_q;
        cout_n   = cout_q;
        corr_n   = corr_q;
        uncorr_n = uncorr_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_n      = a;
                    b_n      = b;
                    carry_n  = cin;
                    k_n      = '0;
                    retry_n  = '0;
                    corr_n   = 1'b0;
                    uncorr_n = 1'b0;
                    state_n  = CALC;
                end
            end
            CALC: begin
                // A total disagreement is retried until the budget runs out, then forced through.
                if ((cls == VOTE_NONE) && (retry_q != RETRY_LIM)) begin
                    retry_n = retry_q + RW'(1);
                end else begin
                    sum_n[k_q*CHUNK +: CHUNK] = vote[CHUNK-1:0];
                    carry_n = vote[CHUNK];
                    retry_n = '0;
                    if (cls == VOTE_TWO)
                        corr_n = 1'b1;
                    if (cls == VOTE_NONE)
                        uncorr_n = 1'b1;
                    if (k_q == LAST_K) begin
                        cout_n  = vote[CHUNK];
                        state_n = DONE;
                    end else begin
                        k_n = k_q + KW'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign sum        = sum_q;
    assign cout       = cout_q;
    assign err_corr   = corr_q;
    assign err_uncorr = uncorr_q;

endmodule

// File: tb/tb_ft_rca_seq.sv
// Directed bench for ft_rca_seq: vector table plus stall, back-to-back and mid-CALC reset sequences.
module tb_ft_rca_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [2:0]  fi_en;
    logic [3:0]  fi_mask;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        err_corr;
    logic        err_uncorr;

    int checks = 0;
    int errors = 0;

    localparam int ALWAYS = 100;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [2:0]  fi_en;
        logic [3:0]  fi_mask;
        int          fi_cycles;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_corr;
        logic        exp_uncorr;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    ft_rca_seq #(
        .WIDTH     (16),
        .CHUNK     (4),
        .RETRY_MAX (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .fi_en      (fi_en),
        .fi_mask    (fi_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .err_corr   (err_corr),
        .err_uncorr (err_uncorr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at the negedge of the first CALC cycle; returns cycles since accept.
    task automatic wait_out(input logic [2:0] en, input int fi_cycles, output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            fi_en = (cyc <= fi_cycles) ? en : 3'b000;
            @(negedge clk);
            cyc++;
        end
        fi_en = 3'b000;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        fi_mask  = v.fi_mask;
        fi_en    = v.fi_en;
        in_valid = 1'b1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(v.fi_en, v.fi_cycles, lat);
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " sum"}, 32'(sum), 32'(v.exp_sum));
        chk({tag, " cout"}, 32'(cout), 32'(v.exp_cout));
        chk({tag, " err_corr"}, 32'(err_corr), 32'(v.exp_corr));
        chk({tag, " err_uncorr"}, 32'(err_uncorr), 32'(v.exp_uncorr));
        handshake(tag);
    endtask

    initial begin
        int          lat;
        logic [15:0] held_sum;

        //          a         b         cin   fi_en   mask     fi_cyc  sum       cout  corr  unc   lat
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 3'b000, 4'b0000, 0,      16'h0000, 1'b1, 1'b0, 1'b0, 5};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 3'b001, 4'b0001, ALWAYS, 16'h5556, 1'b0, 1'b1, 1'b0, 5};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 3'b011, 4'b0001, ALWAYS, 16'h5556, 1'b0, 1'b0, 1'b1, 13};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 3'b011, 4'b0001, 1,      16'h5556, 1'b0, 1'b0, 1'b0, 6};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 3'b000, 4'b0000, 0,      16'h0001, 1'b0, 1'b0, 1'b0, 5};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 3'b000, 4'b0000, 0,      16'hFFFF, 1'b1, 1'b0, 1'b0, 5};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 3'b100, 4'b1000, ALWAYS, 16'hBCDE, 1'b0, 1'b1, 1'b0, 5};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 3'b111, 4'b0001, ALWAYS, 16'h0000, 1'b1, 1'b0, 1'b1, 13};
        // Two replicas flip the same bit 1, so the forced majority is wrong in every chunk.
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 3'b011, 4'b0011, ALWAYS, 16'h2222, 1'b0, 1'b0, 1'b1, 13};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        fi_en     = 3'b000;
        fi_mask   = 4'b0000;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset err_corr", 32'(err_corr), 32'd0);
        chk("reset err_uncorr", 32'(err_uncorr), 32'd0);

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // DONE stall with a competing in_valid, then back-to-back accept after the handshake.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(3'b000, 0, lat);
        chk("stall latency", 32'(lat), 32'd5);
        held_sum = sum;
        chk("stall sum", 32'(held_sum), 32'h5556);
        a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("stall out_valid %0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall sum %0d", i), 32'(sum), 32'h5556);
            chk($sformatf("stall in_ready %0d", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b out_valid", 32'(out_valid), 32'd0);
        chk("b2b in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b accepted", 32'(in_ready), 32'd0);
        wait_out(3'b000, 0, lat);
        chk("b2b latency", 32'(lat), 32'd5);
        chk("b2b sum", 32'(sum), 32'h0003);
        chk("b2b cout", 32'(cout), 32'd0);
        handshake("b2b");

        // Reset during the 2nd CALC cycle after a corrected chunk-0 error.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b1; fi_en = 3'b001; fi_mask = 4'b0001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre-rst err_corr", 32'(err_corr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        fi_en = 3'b000;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst err_corr", 32'(err_corr), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        run_vec(vecs[0], "post-rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ft_rca_seq.md
FT_RCA_SEQ -- requirements
Module: ft_rca_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16: operand width in bits.
REQ-002 The block SHALL take parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be a multiple of CHUNK, checked at elaboration.
REQ-003 The block SHALL take parameter RETRY_MAX, default 2: retries allowed per chunk on an uncorrectable mismatch.
REQ-004 The block SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in
- fi_en  in  3  per-replica fault-inject enable
- fi_mask  in  CHUNK  fault XOR mask
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  voted sum
- cout  out  1  voted carry out
- err_corr  out  1  at least one single-replica error was masked
- err_uncorr  out  1  a chunk exhausted its retries without a 2-of-3 agreement

Function
REQ-006 The FSM SHALL have three states: IDLE, CALC, DONE. in_ready SHALL be 1 only in IDLE.
REQ-007 An accept (in_valid && in_ready) in IDLE SHALL latch a, b and cin, clear the chunk index, retry count and sticky flags, and enter CALC.
REQ-008 Each CALC cycle SHALL process chunk k, bits [k*CHUNK +: CHUNK]:
- Three identical replicas add that chunk using the committed carry; chunk 0 uses the latched cin.
- Each replica produces a CHUNK+1-bit vector {c,s}.
REQ-009 Fault injection SHALL apply to replica r only when fi_en[r]=1: fi_mask rotated left by r bits is XORed into that replica's s. fi_en and fi_mask SHALL be sampled live each CALC cycle.
REQ-010 When all three vectors agree, the block SHALL commit the vector and advance k.
REQ-011 When exactly two vectors agree, the block SHALL commit the majority vector, set err_corr (sticky), and advance k.
REQ-012 When no two vectors agree and the retry count < RETRY_MAX, the block SHALL increment the retry count, hold k, and recompute the chunk on the next cycle.
REQ-013 When no two vectors agree and the retry count = RETRY_MAX, the block SHALL commit the bitwise majority vector, set err_uncorr (sticky), and advance k.
REQ-014 The retry count SHALL reset to 0 on every chunk advance.
REQ-015 After the last chunk (k = WIDTH/CHUNK-1) commits, the block SHALL enter DONE; cout SHALL be the final committed carry.
REQ-016 Fault-free latency SHALL be WIDTH/CHUNK CALC cycles, with out_valid asserted in the cycle after the last CALC cycle. Each retry SHALL add 1 cycle.
REQ-017 In DONE, out_valid SHALL be 1 and sum, cout, err_corr and err_uncorr SHALL be held stable until out_ready=1. The state SHALL then return to IDLE, with out_valid low in the following cycle.
REQ-018 in_valid SHALL be ignored outside IDLE. No new operand SHALL be accepted in the same cycle as the DONE handshake.
REQ-019 Addition SHALL be modulo 2^WIDTH, with the carry out reported on cout.

Reset
REQ-020 rst=1 SHALL force IDLE from any state, including mid-CALC (aborting the operation), and clear:
- out_valid, sum, cout, err_corr, err_uncorr
- chunk index and retry count
- latched operands
REQ-021 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-022 The state enumeration, the {c,s} vector width helper and the vote/compare function SHALL live in shared package ft_rca_pkg.
REQ-023 One sub-module, tmr_chunk_add, SHALL contain the three CHUNK-bit replica adders, the fault injection, the voter and the agreement flags, parametrised by CHUNK.

Verification
REQ-024 The bench SHALL cover these directed scenarios (WIDTH=16, CHUNK=4, RETRY_MAX=2 unless stated):
- a=16'hFFFF, b=16'h0001, cin=0, no faults -> sum=16'h0000, cout=1, err flags 0, out_valid 5 cycles after accept.
- a=16'h1234, b=16'h4321, cin=1, fi_en=3'b001, fi_mask=4'b0001 -> sum=16'h5556, cout=0, err_corr=1, err_uncorr=0, no added latency.
- Same operands, fi_en=3'b011, fi_mask=4'b0001 for the whole run -> each chunk is retried 2 times, err_uncorr=1, out_valid 13 cycles after accept.
- fi_en=3'b011 for the first CALC cycle only, then 0 -> one retry, correct sum, both flags 0, out_valid 6 cycles after accept.
- out_ready held 0 for 4 cycles in DONE -> outputs stable; a new in_valid is not accepted until 1 cycle after the handshake.
- rst pulsed during the 2nd CALC cycle -> next cycle out_valid=0, in_ready=1; the next operation computes correctly.
